// File: rtl/cnn_conv_acc_relu_q.sv
// cnn_conv_acc_relu_q
// Accumulates N_TAPS signed conv products per output pixel, adds a per-window
// bias, rounds half up, shifts right, saturates to OUT_WIDTH and optionally
// applies ReLU. Input and output are valid/ready streams. A finished result
// is held until the consumer takes it. The first product of the next window
// may be accepted in the same cycle that the result is taken.
module cnn_conv_acc_relu_q #(
    parameter int PROD_WIDTH = 21,
    parameter int BIAS_WIDTH = 21,
    parameter int ACC_WIDTH  = 26,
    parameter int OUT_WIDTH  = 14,
    parameter int N_TAPS     = 9,
    parameter int SHIFT      = 6,
    parameter int RELU_EN    = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_len
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] ROUND_C = $signed(ACC_WIDTH'(1) << (SHIFT - 1));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        $signed((ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - ACC_WIDTH'(1));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    state_t                        state_q, state_d;
    logic        [CNT_W-1:0]       tap_cnt_q, tap_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                          err_len_q, err_len_d;

    logic                          in_fire;
    logic                          is_last;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   rounded;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [OUT_WIDTH-1:0]   act;

    // The producer may push whenever we are accumulating, or when the held
    // result is being taken this cycle. This does not depend on in_valid.
    assign in_ready  = (state_q == S_ACC) | out_ready;
    assign in_fire   = in_valid & in_ready;
    assign is_last   = (tap_cnt_q == LAST_TAP);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign err_len   = err_len_q;

    // Datapath: running sum including this product, then requantise and clamp.
    always_comb begin
        // NOTE: every combinational output is given a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        sum     = '0;
        rounded = '0;
        shifted = '0;
        act     = '0;
        // Tap 0 restarts from the bias. The accumulator is not used on tap 0.
        sum     = ((tap_cnt_q == '0) ? ACC_WIDTH'(bias) : acc_q) + ACC_WIDTH'(in_data);
        rounded = sum + ROUND_C;
        shifted = rounded >>> SHIFT;
        if (shifted > OUT_MAX) begin
            act = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            act = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            act = shifted[OUT_WIDTH-1:0];
        end
        if ((RELU_EN != 0) && act[OUT_WIDTH-1]) begin
            act = '0;
        end
    end

    // Next-state logic: framing by tap count, result hand-off, length error.
    always_comb begin
        state_d    = state_q;
        tap_cnt_d  = tap_cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        err_len_d  = err_len_q;

        if ((state_q == S_OUT) && out_ready) begin
            state_d = S_ACC;
        end

        if (in_fire) begin
            // in_last is only checked. It never changes where a window ends.
            if (in_last != is_last) begin
                err_len_d = 1'b1;
            end
            if (is_last) begin
                out_data_d = act;
                state_d    = S_OUT;
                tap_cnt_d  = '0;
            end else begin
                acc_d     = sum;
                tap_cnt_d = tap_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        // NOTE: registers are updated with non-blocking assignments, so each
        // one samples values from before the clock edge, with no ordering race.
        if (!ap_rst_n) begin
            state_q    <= S_ACC;
            tap_cnt_q  <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_cnt_q  <= tap_cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule
